// File: rtl/cpu_pkg.sv
// Shared CPU-wide sizes and types for the integer register path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int NUM_REGISTERS           = 32;
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
    localparam int DATA_WIDTH              = 32;

    typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;
    typedef logic [DATA_WIDTH-1:0]              data_t;

endpackage

// File: rtl/pending_counter.sv
// Per-register count of writes still owed by in-flight instructions.
// Latency: count updates on the clock edge after inc/dec; flags are combinational from count.
// Backpressure: saturates at all-ones (caller gates inc with at_max); dec at zero holds and pulses underflow.
//
// Ports: clk, rst_n (async active-low), inc (reservation fired), dec (writeback),
//        count, nonzero, at_max, underflow (dec with nothing owed and no matching inc).
module pending_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             nonzero,
    output logic             at_max,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    assign nonzero   = (count != '0);
    assign at_max    = (count == MAX_COUNT);
    // A simultaneous inc pays for the dec, so only an unpaired dec at zero is an error.
    assign underflow = dec && !inc && !nonzero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + WIDTH'(1);
        end else if (dec && !inc && nonzero) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/register_scoreboard.sv
// Architectural integer register file plus per-register pending-write scoreboard.
// Latency: reads and contended flags are combinational (writeback bypassed same cycle); state updates on the clock edge.
// Backpressure: reserve_ready drops when the destination's pending counter is saturated; writeback is never stalled.
//
// Ports: clk, rst_n (async active-low);
//        read_1/read_2 _register -> _data, _contended (decode read ports);
//        reserve_valid/_register -> reserve_ready (destination reservation from decode);
//        writeback_valid/_register/_data (result commit);
//        pending_any (any reservation outstanding), error_underflow (sticky).
module register_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
    parameter int NUM_REGISTERS = cpu_pkg::NUM_REGISTERS,
    parameter int PENDING_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [$clog2(NUM_REGISTERS)-1:0] read_1_register,
    output logic [DATA_WIDTH-1:0]            read_1_data,
    output logic                             read_1_contended,
    input  logic [$clog2(NUM_REGISTERS)-1:0] read_2_register,
    output logic [DATA_WIDTH-1:0]            read_2_data,
    output logic                             read_2_contended,
    input  logic                             reserve_valid,
    input  logic [$clog2(NUM_REGISTERS)-1:0] reserve_register,
    output logic                             reserve_ready,
    input  logic                             writeback_valid,
    input  logic [$clog2(NUM_REGISTERS)-1:0] writeback_register,
    input  logic [DATA_WIDTH-1:0]            writeback_data,
    output logic                             pending_any,
    output logic                             error_underflow
);

    localparam int IDX_W = $clog2(NUM_REGISTERS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  contended;
    } read_result_t;

    logic [DATA_WIDTH-1:0]    regfile [NUM_REGISTERS];
    logic [PENDING_WIDTH-1:0] count   [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] nonzero;
    logic [NUM_REGISTERS-1:0] at_max;
    logic [NUM_REGISTERS-1:0] underflow;
    logic [NUM_REGISTERS-1:1] fire_vec;
    logic [NUM_REGISTERS-1:1] wb_vec;
    logic                     reserve_fire;
    read_result_t             port_1;
    read_result_t             port_2;

    // x0 never owes anything: its scoreboard slot is tied off.
    assign count[0]     = '0;
    assign nonzero[0]   = 1'b0;
    assign at_max[0]    = 1'b0;
    assign underflow[0] = 1'b0;

    // Ready looks only at state and the requested index so decode can rely on it before asserting valid.
    assign reserve_ready = (reserve_register == '0) || !at_max[reserve_register];
    assign reserve_fire  = reserve_valid && reserve_ready;

    for (genvar r = 1; r < NUM_REGISTERS; r++) begin : g_pending
        assign fire_vec[r] = reserve_fire && (reserve_register == IDX_W'(r));
        assign wb_vec[r]   = writeback_valid && (writeback_register == IDX_W'(r));

        pending_counter #(
            .WIDTH (PENDING_WIDTH)
        ) u_pending_counter (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (fire_vec[r]),
            .dec       (wb_vec[r]),
            .count     (count[r]),
            .nonzero   (nonzero[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    assign pending_any = |nonzero;

    // Same-cycle writeback is forwarded. If that writeback is the only one owed, the reader
    // is no longer contended; with more owed, a younger write is still outstanding.
    // Same-cycle reservations are deliberately not considered: the reserver reads older state.
    function automatic read_result_t read_port(
        input logic [IDX_W-1:0]         idx,
        input logic [DATA_WIDTH-1:0]    stored,
        input logic [PENDING_WIDTH-1:0] cnt,
        input logic                     wb_vld,
        input logic [IDX_W-1:0]         wb_reg,
        input logic [DATA_WIDTH-1:0]    wb_dat
    );
        read_result_t res;
        logic         bypass;
        bypass        = wb_vld && (wb_reg == idx) && (idx != '0);
        res.data      = bypass ? wb_dat : stored;
        res.contended = bypass ? (cnt > PENDING_WIDTH'(1)) : (cnt != '0);
        return res;
    endfunction

    assign port_1 = read_port(read_1_register, regfile[read_1_register], count[read_1_register],
                              writeback_valid, writeback_register, writeback_data);
    assign port_2 = read_port(read_2_register, regfile[read_2_register], count[read_2_register],
                              writeback_valid, writeback_register, writeback_data);

    assign read_1_data      = port_1.data;
    assign read_1_contended = port_1.contended;
    assign read_2_data      = port_2.data;
    assign read_2_contended = port_2.contended;

    // Data is written on every writeback regardless of scoreboard state; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regfile[i] <= '0;
            end
        end else if (writeback_valid && (writeback_register != '0)) begin
            regfile[writeback_register] <= writeback_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_underflow <= 1'b0;
        end else if (|underflow) begin
            error_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
module tb_register_scoreboard;
    import cpu_pkg::*;

    logic       clk;
    logic       rst_n;
    reg_index_t read_1_register;
    data_t      read_1_data;
    logic       read_1_contended;
    reg_index_t read_2_register;
    data_t      read_2_data;
    logic       read_2_contended;
    logic       reserve_valid;
    reg_index_t reserve_register;
    logic       reserve_ready;
    logic       writeback_valid;
    reg_index_t writeback_register;
    data_t      writeback_data;
    logic       pending_any;
    logic       error_underflow;

    int checks;
    int errors;

    register_scoreboard dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .read_1_register    (read_1_register),
        .read_1_data        (read_1_data),
        .read_1_contended   (read_1_contended),
        .read_2_register    (read_2_register),
        .read_2_data        (read_2_data),
        .read_2_contended   (read_2_contended),
        .reserve_valid      (reserve_valid),
        .reserve_register   (reserve_register),
        .reserve_ready      (reserve_ready),
        .writeback_valid    (writeback_valid),
        .writeback_register (writeback_register),
        .writeback_data     (writeback_data),
        .pending_any        (pending_any),
        .error_underflow    (error_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; checks happen 1ns later, well before the rising edge.
    task automatic idle();
        reserve_valid      = 1'b0;
        reserve_register   = '0;
        writeback_valid    = 1'b0;
        writeback_register = '0;
        writeback_data     = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        read_1_register = 5'd5;
        read_2_register = 5'd0;
        reserve_register = 5'd5;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (read_1_data !== 32'h0 || read_1_contended !== 1'b0) begin
            errors++;
            $display("FAIL reset_x5: data=%h cont=%b expected 00000000/0", read_1_data, read_1_contended);
        end
        checks++;
        if (read_2_data !== 32'h0 || read_2_contended !== 1'b0) begin
            errors++;
            $display("FAIL reset_x0: data=%h cont=%b expected 00000000/0", read_2_data, read_2_contended);
        end
        checks++;
        if (reserve_ready !== 1'b1 || pending_any !== 1'b0 || error_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b pend=%b err=%b expected 1/0/0",
                     reserve_ready, pending_any, error_underflow);
        end
    endtask

    task automatic test_bypass();
        reserve_valid = 1'b1;
        reserve_register = 5'd5;
        read_1_register = 5'd5;
        #1;
        checks++;
        if (read_1_contended !== 1'b0 || reserve_ready !== 1'b1) begin
            errors++;
            $display("FAIL bypass_same_cycle_reserve: cont=%b ready=%b expected 0/1",
                     read_1_contended, reserve_ready);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if (read_1_contended !== 1'b1 || pending_any !== 1'b1) begin
            errors++;
            $display("FAIL bypass_reserved: cont=%b pend=%b expected 1/1", read_1_contended, pending_any);
        end
        writeback_valid = 1'b1;
        writeback_register = 5'd5;
        writeback_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (read_1_data !== 32'hDEADBEEF || read_1_contended !== 1'b0) begin
            errors++;
            $display("FAIL bypass_forward: data=%h cont=%b expected deadbeef/0", read_1_data, read_1_contended);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if (read_1_data !== 32'hDEADBEEF || read_1_contended !== 1'b0 || pending_any !== 1'b0) begin
            errors++;
            $display("FAIL bypass_retired: data=%h cont=%b pend=%b expected deadbeef/0/0",
                     read_1_data, read_1_contended, pending_any);
        end
    endtask

    task automatic test_saturate();
        reserve_valid = 1'b1;
        reserve_register = 5'd7;
        repeat (3) next_cycle();
        reserve_valid = 1'b0;
        #1;
        checks++;
        if (reserve_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_ready_x7: ready=%b expected 0", reserve_ready);
        end
        reserve_register = 5'd8;
        #1;
        checks++;
        if (reserve_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_ready_x8: ready=%b expected 1", reserve_ready);
        end
        // Valid held against a full counter must not fire or wrap.
        reserve_valid = 1'b1;
        reserve_register = 5'd7;
        next_cycle();
        reserve_valid = 1'b0;
        read_2_register = 5'd7;
        writeback_valid = 1'b1;
        writeback_register = 5'd7;
        writeback_data = 32'h11;
        #1;
        checks++;
        if (read_2_data !== 32'h11 || read_2_contended !== 1'b1 || reserve_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_wb_same_cycle: data=%h cont=%b ready=%b expected 00000011/1/0",
                     read_2_data, read_2_contended, reserve_ready);
        end
        next_cycle();
        idle();
        reserve_register = 5'd7;
        #1;
        checks++;
        if (reserve_ready !== 1'b1 || read_2_contended !== 1'b1 || read_2_data !== 32'h11) begin
            errors++;
            $display("FAIL sat_after_wb: ready=%b cont=%b data=%h expected 1/1/00000011",
                     reserve_ready, read_2_contended, read_2_data);
        end
        // Drain the two still owed: count 2 -> 1 -> 0.
        writeback_valid = 1'b1;
        writeback_register = 5'd7;
        writeback_data = 32'h12;
        next_cycle();
        #1;
        checks++;
        if (read_2_contended !== 1'b0 || read_2_data !== 32'h12) begin
            errors++;
            $display("FAIL sat_last_owed: cont=%b data=%h expected 0/00000012", read_2_contended, read_2_data);
        end
        writeback_data = 32'h13;
        next_cycle();
        idle();
        #1;
        checks++;
        if (read_2_contended !== 1'b0 || pending_any !== 1'b0 || error_underflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_drained: cont=%b pend=%b err=%b expected 0/0/0",
                     read_2_contended, pending_any, error_underflow);
        end
    endtask

    task automatic test_simultaneous();
        reserve_valid = 1'b1;
        reserve_register = 5'd9;
        next_cycle();
        read_1_register = 5'd9;
        writeback_valid = 1'b1;
        writeback_register = 5'd9;
        writeback_data = 32'h22;
        #1;
        checks++;
        if (read_1_data !== 32'h22 || read_1_contended !== 1'b0) begin
            errors++;
            $display("FAIL simul_same_cycle: data=%h cont=%b expected 00000022/0", read_1_data, read_1_contended);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if (read_1_contended !== 1'b1 || read_1_data !== 32'h22) begin
            errors++;
            $display("FAIL simul_next: cont=%b data=%h expected 1/00000022", read_1_contended, read_1_data);
        end
        writeback_valid = 1'b1;
        writeback_register = 5'd9;
        writeback_data = 32'h23;
        next_cycle();
        idle();
        #1;
        checks++;
        if (read_1_contended !== 1'b0 || pending_any !== 1'b0 || error_underflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_drained: cont=%b pend=%b err=%b expected 0/0/0",
                     read_1_contended, pending_any, error_underflow);
        end
    endtask

    task automatic test_underflow();
        writeback_valid = 1'b1;
        writeback_register = 5'd3;
        writeback_data = 32'h44;
        read_1_register = 5'd3;
        #1;
        checks++;
        if (error_underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_before_edge: err=%b expected 0", error_underflow);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if (error_underflow !== 1'b1 || read_1_data !== 32'h44 || read_1_contended !== 1'b0) begin
            errors++;
            $display("FAIL uf_set: err=%b data=%h cont=%b expected 1/00000044/0",
                     error_underflow, read_1_data, read_1_contended);
        end
        next_cycle();
        #1;
        checks++;
        if (error_underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_sticky: err=%b expected 1", error_underflow);
        end
        reserve_valid = 1'b1;
        reserve_register = 5'd0;
        writeback_valid = 1'b1;
        writeback_register = 5'd0;
        writeback_data = 32'h55;
        read_2_register = 5'd0;
        #1;
        checks++;
        if (reserve_ready !== 1'b1 || read_2_data !== 32'h0 || read_2_contended !== 1'b0) begin
            errors++;
            $display("FAIL x0_same_cycle: ready=%b data=%h cont=%b expected 1/00000000/0",
                     reserve_ready, read_2_data, read_2_contended);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if (read_2_data !== 32'h0 || read_2_contended !== 1'b0 || pending_any !== 1'b0) begin
            errors++;
            $display("FAIL x0_after: data=%h cont=%b pend=%b expected 00000000/0/0",
                     read_2_data, read_2_contended, pending_any);
        end
    endtask

    task automatic test_async_reset();
        reserve_valid = 1'b1;
        reserve_register = 5'd4;
        read_1_register = 5'd4;
        read_2_register = 5'd3;
        repeat (2) next_cycle();
        idle();
        #1;
        checks++;
        if (read_1_contended !== 1'b1 || pending_any !== 1'b1 || error_underflow !== 1'b1) begin
            errors++;
            $display("FAIL arst_before: cont=%b pend=%b err=%b expected 1/1/1",
                     read_1_contended, pending_any, error_underflow);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pending_any !== 1'b0 || error_underflow !== 1'b0 || read_1_contended !== 1'b0
            || read_2_data !== 32'h0) begin
            errors++;
            $display("FAIL arst_immediate: pend=%b err=%b cont=%b data_x3=%h expected 0/0/0/00000000",
                     pending_any, error_underflow, read_1_contended, read_2_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        read_1_register = '0;
        read_2_register = '0;
        idle();
        rst_n = 1'b0;
        test_reset();
        test_bypass();
        test_saturate();
        test_simultaneous();
        test_underflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
